fifo_pop_stream: RTL and testbench

//  Downstream consumer of the 2-cycle-read SRAM FIFO (d1spfifo). Issues FIFO pops under

---
 rtl/fifo_pop_stream_if.sv | 26 ++
 rtl/fifo_pop_stream.sv | 83 ++++++++
 tb/tb_fifo_pop_stream.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pop_stream_if.sv
// Stream-side bundle between the SRAM FIFO read port, the pop/skid logic and its consumer.
// Handshake: a beat moves on every rising clk where m_valid & m_ready; m_valid never depends on m_ready.
interface fifo_pop_stream_if #(
    parameter int WIDTH = 16
);
    logic             flush;
    logic             fifo_empty;
    logic             fifo_valid;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             err;

    modport master (
        input  flush, fifo_empty, fifo_valid, fifo_rdata, m_ready,
        output fifo_pop, fifo_flush, m_valid, m_data, err
    );

    modport slave (
        output flush, fifo_empty, fifo_valid, fifo_rdata, m_ready,
        input  fifo_pop, fifo_flush, m_valid, m_data, err
    );
endinterface

// File: rtl/fifo_pop_stream.sv
// Credit-controlled popper for a LAT-cycle-read FIFO; returns land in a DEPTH-entry skid
// buffer that is presented as a valid/ready stream. Flush clears FIFO and skid state together.
module fifo_pop_stream #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    fifo_pop_stream_if.master     bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 2);
    localparam int CW = $clog2(DEPTH + LAT + 2) + 1;

    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [OW-1:0]    occ;
    logic [IW-1:0]    inflight;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             err_q;

    logic             deq;
    logic             full;
    logic             ret_any;
    logic             ret_ok;
    logic             err_set;
    logic [CW-1:0]    credit;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        bus.m_valid = (occ != '0);
        bus.m_data  = mem[rd_ptr];
        bus.err     = err_q;
        bus.fifo_flush = bus.flush;

        deq    = bus.m_valid & bus.m_ready & ~bus.flush;
        full   = (occ == OW'(DEPTH));
        // Words already held plus words still on their way must fit after this cycle's dequeue.
        credit = CW'(occ) + CW'(inflight) - CW'(deq);
        bus.fifo_pop = rst_n & ~bus.flush & ~bus.fifo_empty & (credit < CW'(DEPTH));

        ret_any = bus.fifo_valid & ~bus.flush & (inflight != '0);
        ret_ok  = ret_any & ~(full & ~deq);
        err_set = bus.fifo_valid & ~bus.flush & ((inflight == '0) | (full & ~deq));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            inflight <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (bus.flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                occ      <= '0;
                inflight <= '0;
            end else begin
                inflight <= inflight + IW'(bus.fifo_pop) - IW'(ret_any);
                occ      <= occ + OW'(ret_ok) - OW'(deq);
                if (ret_ok) begin
                    mem[wr_ptr] <= bus.fifo_rdata;
                    wr_ptr      <= next_ptr(wr_ptr);
                end
                if (deq) begin
                    rd_ptr <= next_ptr(rd_ptr);
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed bench for fifo_pop_stream with a 2-cycle-read FIFO model and an in-order scoreboard.
module tb_fifo_pop_stream;
    localparam int WIDTH = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_pop_stream_if #(.WIDTH(WIDTH)) bus ();

    fifo_pop_stream #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc, pop_cnt, beats, occ_m, inf_m;
    logic chk_credit, exp_err;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] fq[$];
    logic s1v, s2v;
    logic [WIDTH-1:0] s1d, s2d;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock cycle: sample outputs mid-cycle, score, then advance the FIFO read pipeline.
    task automatic tick();
        logic pop_s, flush_s, deq_s, ret_s;
        logic [WIDTH-1:0] w;
        #1;
        pop_s   = bus.fifo_pop;
        flush_s = bus.flush;
        deq_s   = bus.m_valid & bus.m_ready & ~bus.flush;
        ret_s   = bus.fifo_valid & ~bus.flush & (inf_m != 0);
        check_bit("err", bus.err, exp_err);
        check_bit("fifo_flush", bus.fifo_flush, flush_s);
        if (pop_s) begin
            pop_cnt++;
            check_bit("pop_nonempty", fq.size() > 0, 1'b1);
        end
        if (deq_s) begin
            if (exp_q.size() == 0) begin
                check_int("beat_unexpected", int'(bus.m_data), -1);
            end else begin
                w = exp_q.pop_front();
                check_word("beat_data", bus.m_data, w);
                beats++;
            end
        end
        if (flush_s) begin
            occ_m = 0;
            inf_m = 0;
        end else begin
            occ_m = occ_m + int'(ret_s) - int'(deq_s);
            inf_m = inf_m + int'(pop_s) - int'(ret_s);
        end
        if (chk_credit) begin
            check_bit("credit_le_depth", (occ_m + inf_m) <= DEPTH, 1'b1);
            check_bit("inflight_le_3", inf_m <= LAT + 1, 1'b1);
        end
        @(posedge clk);
        #1;
        cyc++;
        s2v = flush_s ? 1'b0 : s1v;
        s2d = s1d;
        s1v = pop_s;
        if (pop_s && fq.size() > 0) s1d = fq.pop_front();
        if (flush_s) begin
            fq.delete();
            exp_q.delete();
        end
        bus.fifo_valid = s2v;
        bus.fifo_rdata = s2v ? s2d : '0;
        bus.fifo_empty = (fq.size() == 0);
        #1;
    endtask

    initial begin
        cyc = 0; pop_cnt = 0; beats = 0; occ_m = 0; inf_m = 0;
        chk_credit = 1'b0; exp_err = 1'b0;
        s1v = 1'b0; s2v = 1'b0; s1d = '0; s2d = '0;
        bus.flush = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_valid = 1'b0;
        bus.fifo_rdata = '0; bus.m_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_m_valid", bus.m_valid, 1'b0);
        check_word("rst_m_data", bus.m_data, 16'h0000);
        check_bit("rst_err", bus.err, 1'b0);
        check_bit("rst_fifo_flush", bus.fifo_flush, 1'b0);
        bus.fifo_empty = 1'b0;
        #1;
        check_bit("rst_fifo_pop", bus.fifo_pop, 1'b0);
        bus.fifo_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // 1: preloaded FIFO, free-running consumer
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(16'h0011 + 16'(i));
        cyc = 0; beats = 0;
        #1;
        check_bit("t1_pop_cycle0", bus.fifo_pop, 1'b1);
        tick();
        tick();
        check_bit("t1_valid_cycle2", bus.m_valid, 1'b0);
        tick();
        check_bit("t1_valid_cycle3", bus.m_valid, 1'b1);
        check_word("t1_first_word", bus.m_data, 16'h0011);
        for (int i = 0; i < 8; i++) begin
            check_bit("t1_stream_valid", bus.m_valid, 1'b1);
            tick();
        end
        check_int("t1_beats", beats, 8);
        check_bit("t1_idle_valid", bus.m_valid, 1'b0);

        // 2: stalled consumer, credit limits pops to DEPTH
        bus.m_ready = 1'b0;
        pop_cnt = 0; beats = 0;
        for (int i = 0; i < 6; i++) push(16'h0021 + 16'(i));
        repeat (10) tick();
        check_int("t2_pop_count", pop_cnt, 4);
        check_bit("t2_valid_held", bus.m_valid, 1'b1);
        check_word("t2_head", bus.m_data, 16'h0021);
        tick();
        check_word("t2_head_stable", bus.m_data, 16'h0021);
        bus.m_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        check_int("t2_drained", exp_q.size(), 0);
        check_int("t2_beats", beats, 6);
        repeat (3) tick();

        // 3: toggling backpressure
        chk_credit = 1'b1;
        beats = 0;
        for (int i = 0; i < 20; i++) push(16'h0030 + 16'(i));
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            bus.m_ready = (k % 2 == 0);
            tick();
        end
        chk_credit = 1'b0;
        check_int("t3_drained", exp_q.size(), 0);
        check_int("t3_beats", beats, 20);
        bus.m_ready = 1'b1;
        repeat (3) tick();

        // 4: flush mid-stream, then a fresh word
        for (int i = 0; i < 10; i++) push(16'h0040 + 16'(i));
        repeat (5) tick();
        bus.flush = 1'b1;
        #1;
        check_bit("t4_flush_fwd", bus.fifo_flush, 1'b1);
        check_bit("t4_no_pop", bus.fifo_pop, 1'b0);
        tick();
        bus.flush = 1'b0;
        check_bit("t4_valid_after_flush", bus.m_valid, 1'b0);
        beats = 0;
        push(16'h00AA);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check_int("t4_aa_out", beats, 1);
        repeat (4) tick();
        check_int("t4_no_stale", beats, 1);

        // 5: unsolicited return
        repeat (3) tick();
        bus.fifo_valid = 1'b1;
        bus.fifo_rdata = 16'hDEAD;
        tick();
        exp_err = 1'b1;
        check_bit("t5_err_set", bus.err, 1'b1);
        check_bit("t5_not_enqueued", bus.m_valid, 1'b0);
        repeat (3) tick();
        check_bit("t5_err_sticky", bus.err, 1'b1);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) push(16'h0051 + 16'(i));
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("t6_rst_valid", bus.m_valid, 1'b0);
        check_bit("t6_rst_pop", bus.fifo_pop, 1'b0);
        check_bit("t6_rst_err", bus.err, 1'b0);
        fq.delete(); exp_q.delete();
        s1v = 1'b0; s2v = 1'b0; occ_m = 0; inf_m = 0; exp_err = 1'b0;
        bus.fifo_valid = 1'b0; bus.fifo_rdata = '0; bus.fifo_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        beats = 0;
        for (int i = 0; i < 3; i++) push(16'h0061 + 16'(i));
        #1;
        check_bit("t6_restart_pop", bus.fifo_pop, 1'b1);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check_int("t6_restart_beats", beats, 3);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
